// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Works on operand magnitudes: shift-add
// multiply on a 2N-bit accumulator, restoring divide on an N+1-bit partial
// remainder, both retiring BITS_PER_CYCLE bits per cycle, then sign-correct
// on the way into the registered result.
module riscv_muldiv_unit #(
    parameter int unsigned N              = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   funct3,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         abort,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);
    localparam int unsigned B    = BITS_PER_CYCLE;
    localparam int unsigned S    = N / BITS_PER_CYCLE;
    localparam int unsigned CntW = (S > 1) ? $clog2(S) : 1;
    localparam int unsigned W2   = 2 * N;
    localparam logic [N-1:0] MinVal = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            sign_q, sign_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    opa_q, opa_d;     // multiplicand, or dividend shifting into quotient
    logic [N-1:0]    opb_q, opb_d;     // multiplier shifting out, or divisor
    logic [W2-1:0]   acc_q, acc_d;
    logic [N:0]      rem_q, rem_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [N-1:0]    result_q, result_d;

    logic            a_sgn, b_sgn, a_neg, b_neg, sign_in;
    logic [N-1:0]    a_mag, b_mag;
    logic            div_zero, div_ovf, fast;
    logic [N-1:0]    fast_res;

    // Decode the incoming request: magnitudes, result sign and fast-path cases.
    always_comb begin
        a_sgn    = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_sgn    = funct3[2] ? ~funct3[0] : ~funct3[1];
        a_neg    = a_sgn & a[N-1];
        b_neg    = b_sgn & b[N-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        // Remainder takes the dividend's sign; everything else the XOR.
        sign_in  = (funct3[2] & funct3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = funct3[2] & (b == '0);
        div_ovf  = funct3[2] & ~funct3[0] & (a == MinVal) & (&b);
        fast     = div_zero | div_ovf;
        if (div_zero) fast_res = funct3[1] ? a : '1;
        else          fast_res = funct3[1] ? '0 : a;
    end

    logic [B-1:0]      digit;
    logic [N+B-1:0]    partial, hi_sum;
    logic [W2+B-1:0]   wide;
    logic [W2-1:0]     acc_step, prod_s;
    logic [N-1:0]      opb_step;
    logic [N:0]        div_r, div_diff;
    logic [N-1:0]      div_q, mul_res, div_val, div_res, run_res;

    // One iteration of each datapath plus the sign-corrected final result.
    always_comb begin
        digit    = opb_q[B-1:0];
        partial  = {{B{1'b0}}, opa_q} * {{N{1'b0}}, digit};
        hi_sum   = {{B{1'b0}}, acc_q[W2-1:N]} + partial;
        wide     = {hi_sum, acc_q[N-1:0]};
        acc_step = W2'(wide >> B);
        opb_step = opb_q >> B;

        div_r    = rem_q;
        div_q    = opa_q;
        div_diff = '0;
        for (int i = 0; i < int'(B); i++) begin
            div_r    = {div_r[N-1:0], div_q[N-1]};
            div_q    = {div_q[N-2:0], 1'b0};
            div_diff = div_r - {1'b0, opb_q};
            if (!div_diff[N]) begin
                div_r    = div_diff;
                div_q[0] = 1'b1;
            end
        end

        // Negate the full product so the high half is correct for MULH*.
        prod_s  = sign_q ? -acc_step : acc_step;
        mul_res = (op_q[1:0] == 2'b00) ? prod_s[N-1:0] : prod_s[W2-1:N];
        div_val = op_q[1] ? div_r[N-1:0] : div_q;
        div_res = sign_q ? -div_val : div_val;
        run_res = op_q[2] ? div_res : mul_res;
    end

    // Next-state logic for the IDLE/RUN/DONE sequencer and datapath registers.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                if (start) begin
                    op_d   = funct3;
                    sign_d = sign_in;
                    opa_d  = a_mag;
                    opb_d  = b_mag;
                    cnt_d  = '0;
                    acc_d  = '0;
                    rem_d  = '0;
                    busy_d = 1'b1;
                    if (fast) begin
                        state_d  = StDone;
                        done_d   = 1'b1;
                        result_d = fast_res;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q[2]) begin
                    opa_d = div_q;
                    rem_d = div_r;
                end else begin
                    acc_d = acc_step;
                    opb_d = opb_step;
                end
                if (cnt_q == CntW'(S - 1)) begin
                    state_d  = StDone;
                    done_d   = 1'b1;
                    result_d = run_res;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase

        // Flush wins over everything, including a simultaneous start.
        if (abort) begin
            state_d  = StIdle;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            op_q     <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Bench for riscv_muldiv_unit: a radix-2 instance for directed timing and
// control checks, a radix-16 instance for a random back-to-back regression
// against an arithmetic reference model.
module tb_riscv_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start4;
    logic [2:0]  funct3;
    logic [31:0] a, b;
    logic        abort;
    logic        busy1, done1, busy4, done4;
    logic [31:0] result1, result4;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_exp;

    always #5 clk = ~clk;

    riscv_muldiv_unit #(.N(32), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .funct3(funct3), .a(a), .b(b),
        .abort(abort), .busy(busy1), .done(done1), .result(result1)
    );

    riscv_muldiv_unit #(.N(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .funct3(funct3), .a(a), .b(b),
        .abort(abort), .busy(busy4), .done(done4), .result(result4)
    );

    // RV32M semantics computed directly in 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x,
                                              input logic [31:0] y);
        longint sx, sy, ux, uy;
        logic [63:0] p;
        logic ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = longint'({32'd0, x});
        uy  = longint'({32'd0, y});
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        p   = '0;
        case (f)
            3'd0: begin p = 64'(sx * sy); return p[31:0]; end
            3'd1: begin p = 64'(sx * sy); return p[63:32]; end
            3'd2: begin p = 64'(sx * uy); return p[63:32]; end
            3'd3: begin p = 64'(ux * uy); return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf) return x;
                p = 64'(sx / sy); return p[31:0];
            end
            3'd5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                p = 64'(ux / uy); return p[31:0];
            end
            3'd6: begin
                if (y == 0) return x;
                if (ovf) return 32'd0;
                p = 64'(sx % sy); return p[31:0];
            end
            default: begin
                if (y == 0) return x;
                p = 64'(ux % uy); return p[31:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 9))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Issue one operation and report what the DUT did; callers do the checks.
    task automatic run_op(input bit use4, input logic [2:0] f, input logic [31:0] x,
                          input logic [31:0] y, output logic [31:0] res, output int cyc,
                          output bit busy_ok);
        @(negedge clk);
        funct3 = f; a = x; b = y;
        if (use4) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0; start4 = 1'b0;
        res = '0; cyc = 0; busy_ok = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (!(use4 ? busy4 : busy1)) busy_ok = 1'b0;
            if (use4 ? done4 : done1) begin
                cyc = k;
                res = use4 ? result4 : result1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start1 = 1'b0; start4 = 1'b0; abort = 1'b0;
        funct3 = '0; a = '0; b = '0;
        #12;
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset busy1: got %b want 0", busy1); end
        n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset done1: got %b want 0", done1); end
        n_checks++; if (result1 !== 32'd0) begin n_fail++; $display("FAIL reset result1: got %h want 0", result1); end
        n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset busy4: got %b want 0", busy4); end
        n_checks++; if (result4 !== 32'd0) begin n_fail++; $display("FAIL reset result4: got %h want 0", result4); end
        @(negedge clk);
        rst = 1'b1;
        last_exp = 32'd0;
    endtask

    task automatic test_mul_timing();
        logic [31:0] res; int cyc; bit bok;
        run_op(1'b0, 3'd0, 32'd7, 32'hFFFF_FFFD, res, cyc, bok);
        n_checks++; if (res !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul result: got %h want ffffffeb", res); end
        n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL mul done cycle: got %0d want 33", cyc); end
        n_checks++; if (!bok) begin n_fail++; $display("FAIL mul busy window: busy dropped before done"); end
        @(negedge clk);
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL mul busy after done: got %b want 0", busy1); end
        n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL mul done width: got %b want 0", done1); end
        last_exp = 32'hFFFF_FFEB;
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] x, y, exp;
        int          cyc;
    } vec_t;

    task automatic test_directed_ops();
        vec_t v[13];
        logic [31:0] res; int cyc; bit bok;
        v = '{
            '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33},
            '{3'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 33},
            '{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33},
            '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33},
            '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33},
            '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33},
            '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         33},
            '{3'd5, 32'd100,       32'd7,         32'd14,        33},
            '{3'd7, 32'd100,       32'd7,         32'd2,         33},
            '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1},
            '{3'd6, 32'd5,         32'd0,         32'd5,         1},
            '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
            '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1}
        };
        for (int i = 0; i < 13; i++) begin
            run_op(1'b0, v[i].f, v[i].x, v[i].y, res, cyc, bok);
            n_checks++;
            if (res !== v[i].exp) begin
                n_fail++;
                $display("FAIL directed[%0d] f=%0d result: got %h want %h", i, v[i].f, res, v[i].exp);
            end
            n_checks++;
            if (cyc != v[i].cyc) begin
                n_fail++;
                $display("FAIL directed[%0d] done cycle: got %0d want %0d", i, cyc, v[i].cyc);
            end
        end
        last_exp = 32'd0;
    endtask

    task automatic test_abort();
        bit saw_done;
        @(negedge clk);
        funct3 = 3'd4; a = 32'hFFFF_FFF9; b = 32'd2; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int k = 1; k <= 9; k++) @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL abort busy in cycle 10: got %b want 1", busy1); end
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL abort busy in cycle 11: got %b want 0", busy1); end
        n_checks++; if (result1 !== last_exp) begin n_fail++; $display("FAIL abort result kept: got %h want %h", result1, last_exp); end
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done1) saw_done = 1'b1;
        end
        n_checks++; if (saw_done) begin n_fail++; $display("FAIL abort no done: got done=1 want none"); end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        @(negedge clk);
        funct3 = 3'd0; a = 32'd7; b = 32'hFFFF_FFFD; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int k = 1; k <= 4; k++) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL midreset busy: got %b want 0", busy1); end
        n_checks++; if (result1 !== 32'd0) begin n_fail++; $display("FAIL midreset result: got %h want 0", result1); end
        @(negedge clk);
        rst = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done1) saw_done = 1'b1;
        end
        n_checks++; if (saw_done) begin n_fail++; $display("FAIL midreset no done: got done=1 want none"); end
        last_exp = 32'd0;
    endtask

    task automatic test_start_in_run();
        int cyc;
        logic [31:0] res;
        @(negedge clk);
        funct3 = 3'd5; a = 32'd100; b = 32'd7; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        cyc = 0; res = '0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 5) begin funct3 = 3'd0; a = 32'd3; b = 32'd3; start1 = 1'b1; end
            if (k == 6) start1 = 1'b0;
            if (done1) begin cyc = k; res = result1; break; end
        end
        n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL start-in-run result: got %h want 0000000e", res); end
        n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL start-in-run done cycle: got %0d want 33", cyc); end
        @(negedge clk);
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL start-in-run queued: busy=%b want 0", busy1); end
    endtask

    // Random ops on the radix-16 instance with start held high throughout.
    task automatic test_random_b2b();
        logic [2:0]  f;
        logic [31:0] x, y, exp;
        bit fast, bok;
        int cyc, want;
        f = 3'($urandom_range(0, 7)); x = pick_operand(); y = pick_operand();
        @(negedge clk);
        funct3 = f; a = x; b = y; start4 = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk);
            exp  = ref_model(f, x, y);
            fast = f[2] && ((y == 0) || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
            want = fast ? 1 : 9;
            cyc = 0; bok = 1'b1;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (!busy4) bok = 1'b0;
                if (done4) begin
                    cyc = k;
                    n_checks++;
                    if (result4 !== exp) begin
                        n_fail++;
                        $display("FAIL random[%0d] f=%0d a=%h b=%h result: got %h want %h",
                                 n, f, x, y, result4, exp);
                    end
                    f = 3'($urandom_range(0, 7)); x = pick_operand(); y = pick_operand();
                    funct3 = f; a = x; b = y;
                    if (n == 999) start4 = 1'b0;
                    break;
                end
            end
            n_checks++;
            if (cyc != want) begin
                n_fail++;
                $display("FAIL random[%0d] done cycle: got %0d want %0d", n, cyc, want);
            end
            n_checks++;
            if (!bok) begin n_fail++; $display("FAIL random[%0d] busy gap: busy low before done", n); end
            if (cyc == 0) begin start4 = 1'b0; break; end
        end
        start4 = 1'b0;
        @(negedge clk);
        n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL random idle after last: busy=%b want 0", busy4); end
    endtask

    initial begin
        test_reset();
        test_mul_timing();
        test_directed_ops();
        test_abort();
        test_reset_mid();
        test_start_in_run();
        test_random_b2b();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
